// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the fetch stage and the decode stage that consumes
// F_instr: fetch FSM encoding, reset PC default, instruction field positions,
// the JAL link register and the branch offset helper.
package instr_fetch_pkg;

  // Fetch FSM encoding (2 bits)
  localparam logic [1:0] ST_IDLE = 2'd0;  // first cycle out of reset
  localparam logic [1:0] ST_WAIT = 2'd1;  // request outstanding
  localparam logic [1:0] ST_HOLD = 2'd2;  // output held by decode stall
  localparam logic [1:0] ST_DROP = 2'd3;  // draining a killed request

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  // Instruction word field positions, shared with decode
  localparam int OP_MSB     = 31;
  localparam int OP_LSB     = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int IMME_MSB   = 15;
  localparam int IMME_LSB   = 0;
  localparam int J_IMME_MSB = 25;
  localparam int J_IMME_LSB = 0;

  localparam logic [4:0] JAL_LINK_REG = 5'd31;

  // Word offset -> signed byte offset
  function automatic logic [31:0] branch_offset(input logic [15:0] imme);
    return {{14{imme[15]}}, imme, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC mux for the fetch stage (combinational only).
//   i_pc        current fetch pc        -> o_seq_pc = i_pc + PC_STEP
//   i_f_pc      pc of the instruction being consumed (redirect base)
//   i_jump_en / i_j_imme     J/JAL redirect
//   i_branch_en / i_imme     taken branch redirect (word offset)
//   o_target    redirect target (jump wins over branch)
//   o_redirect  either redirect requested
module fetch_next_pc
  import instr_fetch_pkg::*;
#(
  parameter int PC_STEP = 4
) (
  input  logic [31:0] i_pc,
  input  logic [31:0] i_f_pc,
  input  logic        i_jump_en,
  input  logic [25:0] i_j_imme,
  input  logic        i_branch_en,
  input  logic [15:0] i_imme,
  output logic [31:0] o_seq_pc,
  output logic [31:0] o_target,
  output logic        o_redirect
);

  logic [31:0] w_link;  // address after the redirecting instruction

  assign w_link     = i_f_pc + 32'd4;
  assign o_seq_pc   = i_pc + 32'(PC_STEP);
  assign o_redirect = i_jump_en | i_branch_en;

  always_comb begin
    o_target = w_link + branch_offset(i_imme);
    if (i_jump_en) o_target = {w_link[31:28], i_j_imme, 2'b00};
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage. Owns the PC, keeps a single read outstanding to
// instruction memory and presents one word at a time to decode.
//   clk, rst                 clock, async active-low reset
//   imem_req/imem_addr       read request (held until imem_rvalid), addr = pc
//   imem_rvalid/imem_rdata   read return
//   stall                    decode cannot take F_instr this cycle
//   ID_jump_en/ID_j_imme     jump redirect from decode
//   ID_branch_en/ID_imme     taken branch redirect from decode
//   F_instr/F_pc/F_valid     instruction presented to decode
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int          PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        ID_jump_en,
  input  logic [25:0] ID_j_imme,
  input  logic        ID_branch_en,
  input  logic [15:0] ID_imme,
  output logic [31:0] F_instr,
  output logic [31:0] F_pc,
  output logic        F_valid
);

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_fpc;
  logic        r_fvalid;

  logic [31:0] w_seq_pc;
  logic [31:0] w_target;
  logic        w_redir_req;
  logic        w_consume;
  logic        w_redirect;
  logic        w_busy;

  fetch_next_pc #(.PC_STEP(PC_STEP)) u_next_pc (
    .i_pc        (r_pc),
    .i_f_pc      (r_fpc),
    .i_jump_en   (ID_jump_en),
    .i_j_imme    (ID_j_imme),
    .i_branch_en (ID_branch_en),
    .i_imme      (ID_imme),
    .o_seq_pc    (w_seq_pc),
    .o_target    (w_target),
    .o_redirect  (w_redir_req)
  );

  // Redirects belong to the instruction being consumed, so only honour them
  // on a consuming edge.
  assign w_consume  = r_fvalid & ~stall;
  assign w_redirect = w_consume & w_redir_req;
  assign w_busy     = r_fvalid & stall;

  assign imem_req  = (r_state == ST_WAIT);
  assign imem_addr = r_pc;
  assign F_instr   = r_instr;
  assign F_pc      = r_fpc;
  assign F_valid   = r_fvalid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_pc     <= RESET_PC;
      r_instr  <= 32'd0;
      r_fpc    <= 32'd0;
      r_fvalid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: r_state <= ST_WAIT;

        ST_WAIT: begin
          if (w_redirect) begin
            r_pc     <= w_target;
            r_fvalid <= 1'b0;
            // Data returning on the redirect edge is simply dropped; with
            // nothing left in flight the target is requested next cycle.
            if (!imem_rvalid) r_state <= ST_DROP;
          end else if (imem_rvalid && !w_busy) begin
            r_instr  <= imem_rdata;
            r_fpc    <= r_pc;
            r_fvalid <= 1'b1;
            r_pc     <= w_seq_pc;
            r_state  <= stall ? ST_HOLD : ST_WAIT;
          end else if (w_consume) begin
            r_fvalid <= 1'b0;
          end
          // rvalid while the output is still held: the word is discarded and,
          // since pc is unchanged and imem_req stays high, the same address is
          // requested again.
        end

        ST_HOLD: begin
          if (!stall || !r_fvalid) begin
            r_state  <= ST_WAIT;
            r_fvalid <= 1'b0;
            if (w_redirect) r_pc <= w_target;
          end
        end

        ST_DROP: begin
          if (imem_rvalid) r_state <= ST_WAIT;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        stall = 1'b0;
  logic        ID_jump_en = 1'b0;
  logic [25:0] ID_j_imme = 26'd0;
  logic        ID_branch_en = 1'b0;
  logic [15:0] ID_imme = 16'd0;
  logic [31:0] F_instr;
  logic [31:0] F_pc;
  logic        F_valid;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .ID_jump_en   (ID_jump_en),
    .ID_j_imme    (ID_j_imme),
    .ID_branch_en (ID_branch_en),
    .ID_imme      (ID_imme),
    .F_instr      (F_instr),
    .F_pc         (F_pc),
    .F_valid      (F_valid)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] exp_q[$];   // {pc, instr} expected on each consumption
  logic [31:0] addr_q[$];  // expected request addresses in order

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h2001_0005;
      32'h0000_0004: return 32'h2002_0007;
      default:       return a ^ 32'h3C00_0000;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push_out(input logic [31:0] pcs[$]);
    foreach (pcs[i]) exp_q.push_back({pcs[i], mem_word(pcs[i])});
  endtask

  task automatic push_req(input logic [31:0] a[$]);
    foreach (a[i]) addr_q.push_back(a[i]);
  endtask

  // Memory responder: one request at a time, rvalid lat cycles after the
  // request is first seen. Keeps counting through reset so a stray rvalid
  // can land on a freshly reset fetch unit.
  int          lat = 1;
  int          m_cnt = 0;
  logic        m_busy = 1'b0;
  logic [31:0] m_addr = 32'd0;

  always @(negedge clk) begin
    if (imem_rvalid) begin
      imem_rvalid = 1'b0;
      m_busy      = 1'b0;
    end
    if (!m_busy && imem_req) begin
      m_busy = 1'b1;
      m_cnt  = lat;
      m_addr = imem_addr;
      if (addr_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL req_unexpected: got addr %h want no request", imem_addr);
      end else begin
        check("req_addr", 64'(imem_addr), 64'(addr_q.pop_front()));
      end
    end else if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(m_addr);
      end
    end
  end

  // Output monitor: compare every consumed instruction with the scoreboard.
  logic [63:0] mon_exp;
  always @(negedge clk) begin
    #2;
    if (rst && F_valid && !stall) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL out_unexpected: got pc %h instr %h want none", F_pc, F_instr);
      end else begin
        mon_exp = exp_q.pop_front();
        check("out_pc_instr", {F_pc, F_instr}, mon_exp);
      end
    end
  end

  task automatic wait_fv(input logic [31:0] pc);
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!(F_valid && F_pc == pc) && n < 60);
    if (!(F_valid && F_pc == pc)) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_fv: got F_pc %h valid %b want pc %h presented", F_pc, F_valid, pc);
    end
  endtask

  // Drive a redirect for the instruction on F_instr this cycle; the next
  // cycle must show no request and no valid output.
  task automatic redirect(input logic j, input logic [25:0] ji, input logic b, input logic [15:0] bi);
    ID_jump_en = j;  ID_j_imme = ji;
    ID_branch_en = b; ID_imme = bi;
    @(negedge clk); #1;
    ID_jump_en = 1'b0;
    ID_branch_en = 1'b0;
    check("redir_quiet", 64'({imem_req, F_valid}), 64'(2'b00));
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    #1;
    check("rst_ctl",  64'({imem_req, F_valid}), 64'(2'b00));
    check("rst_addr", 64'(imem_addr), 64'(32'h0));
    check("rst_fout", {F_pc, F_instr}, 64'd0);

    // Sequential fetch, then stall on 0x8
    push_out({32'h0, 32'h4, 32'h8});
    push_req({32'h0, 32'h4, 32'h8, 32'hC});
    rst = 1'b1;
    #1 check("idle_req", 64'(imem_req), 64'd0);
    wait_fv(32'h0);
    wait_fv(32'h4);
    @(negedge clk); #1;
    stall = 1'b1;  // rvalid for 0x8 is present this cycle
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("hold_ctl",  64'({F_valid, imem_req}), 64'(2'b10));
      check("hold_data", {F_pc, F_instr}, {32'h8, mem_word(32'h8)});
    end
    @(negedge clk); #1;
    stall = 1'b0;
    @(negedge clk); #1;
    check("resume_ctl",  64'({imem_req, F_valid}), 64'(2'b10));
    check("resume_addr", 64'(imem_addr), 64'(32'hC));

    // Branches, jump+branch priority, jump nibble, pc wrap (1-cycle memory)
    push_out({32'hC, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h20,
              32'h14, 32'h18, 32'h1C, 32'h20, 32'h30,
              32'hFFFF_FFF8, 32'hF000_0100, 32'hF000_0104,
              32'hFFFF_FFFC, 32'h0});
    push_req({32'h10, 32'h14, 32'h18, 32'h1C, 32'h20, 32'h24,
              32'h14, 32'h18, 32'h1C, 32'h20, 32'h24, 32'h30, 32'h34,
              32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'hF000_0100, 32'hF000_0104,
              32'hF000_0108, 32'hFFFF_FFFC, 32'h0, 32'h4});
    wait_fv(32'h20);
    redirect(1'b0, 26'd0, 1'b1, 16'hFFFC);           // -> 0x14
    wait_fv(32'h20);
    redirect(1'b0, 26'd0, 1'b1, 16'h0003);           // -> 0x30
    wait_fv(32'h30);
    redirect(1'b0, 26'd0, 1'b1, 16'hFFF1);           // -> 0xFFFF_FFF8
    wait_fv(32'hFFFF_FFF8);
    redirect(1'b1, 26'h000_0040, 1'b1, 16'h0001);    // jump wins -> 0xF000_0100
    wait_fv(32'hF000_0104);
    redirect(1'b1, 26'h3FF_FFFF, 1'b0, 16'h0000);    // -> 0xFFFF_FFFC
    wait_fv(32'hFFFF_FFFC);
    wait_fv(32'h0);                                  // wrapped
    lat = 4;

    // Redirect with a slow request outstanding -> drained and discarded
    push_out({32'h4, 32'h48});
    push_req({32'h8, 32'h48, 32'h4C});
    wait_fv(32'h4);
    redirect(1'b0, 26'd0, 1'b1, 16'h0010);           // -> 0x48
    @(negedge clk); #1;
    check("drop_still_quiet", 64'({imem_req, F_valid}), 64'(2'b00));
    wait_fv(32'h48);

    // Reset mid-request; the stale rvalid lands during reset/IDLE
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_mid_ctl",  64'({imem_req, F_valid}), 64'(2'b00));
    check("rst_mid_fout", {F_pc, F_instr}, 64'd0);
    repeat (3) @(negedge clk);
    #1;
    check("rst_rvalid_ctl",  64'({imem_req, F_valid}), 64'(2'b00));
    check("rst_rvalid_addr", 64'(imem_addr), 64'(32'h0));
    push_out({32'h0});
    push_req({32'h0, 32'h4});
    rst = 1'b1;
    @(negedge clk); #1;
    check("post_rst_ctl",  64'({imem_req, F_valid}), 64'(2'b10));
    check("post_rst_addr", 64'(imem_addr), 64'(32'h0));
    wait_fv(32'h0);
    repeat (2) @(negedge clk);
    #3;
    check("out_q_drained", 64'(exp_q.size()), 64'd0);
    check("req_q_drained", 64'(addr_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch stage. Owns the PC and issues single-outstanding reads to instruction memory.
- Presents one fetched word per accepted instruction on F_instr, the producer end of the instruction bus the decode stage slices into op/rs/rt/rd/funct/imme.
- Accepts jump and branch redirects from decode. No branch delay slot.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
PC_STEP, 4, byte increment per sequential instruction.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
imem_req  out  1  read request, held until imem_rvalid.
imem_addr  out  32  read address, equal to pc while imem_req=1.
imem_rvalid  in  1  read data valid, at least 1 cycle after request.
imem_rdata  in  32  instruction word.
stall  in  1  decode cannot accept F_instr this cycle.
ID_jump_en  in  1  J/JAL redirect from decode.
ID_j_imme  in  26  jump index.
ID_branch_en  in  1  taken-branch redirect from decode.
ID_imme  in  16  branch offset, in words.
F_instr  out  32  instruction to decode.
F_pc  out  32  address of F_instr.
F_valid  out  1  F_instr is valid.

Behaviour:
- Reset is asynchronous and active-low.
  - While rst=0: pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC, F_instr=0, F_pc=0, F_valid=0, drop=0.
- States:
  - IDLE: first cycle after reset only. Goes to WAIT with imem_req=1.
  - WAIT: imem_req=1, imem_addr=pc. On imem_rvalid: F_instr<=imem_rdata, F_pc<=pc, F_valid<=1, pc<=pc+PC_STEP.
    - If stall=0 and no redirect: stay in WAIT and issue the next request.
    - If stall=1: go to HOLD.
  - HOLD: imem_req=0. Outputs frozen while stall=1. On stall=0: go to WAIT.
  - DROP: imem_req=0. Waits for imem_rvalid of a killed request, discards it, then goes to WAIT with the updated pc.
- Consumption: an instruction is consumed on any edge where F_valid=1 and stall=0.
  - After consumption with no new data that cycle, F_valid<=0.
- Redirect:
  - Sampled only when F_valid=1 and stall=0, because redirects belong to the instruction being consumed.
  - Jump target = {F_pc+4 [31:28], ID_j_imme, 2'b00}.
  - Branch target = F_pc + 4 + (sign_extend(ID_imme) << 2), 32-bit wrap-around.
  - If both are asserted, jump has priority.
  - On redirect: pc<=target and F_valid<=0 next cycle.
  - If a request is outstanding (WAIT, rvalid not yet seen), go to DROP.
  - If rvalid arrives in the same cycle as the redirect, discard that data and go to WAIT with the target.
- Latency:
  - Request to F_valid = memory latency + 1 edge.
  - Throughput is 1 instruction per (latency+1) cycles. Only one request is ever outstanding.
- Boundaries:
  - pc wraps 32'hFFFF_FFFC -> 0.
  - stall is ignored when F_valid=0.
  - imem_rvalid outside WAIT/DROP is ignored.
  - Reset asserted mid-request aborts it; a later stray rvalid while in IDLE is ignored.

Decomposition:
- Shared package:
  - fetch state encoding (IDLE/WAIT/HOLD/DROP, 2 bits);
  - RESET_PC default;
  - opcode/field bit positions shared with decode: op [31:26], rs [25:21], rt [20:16], rd [15:11], imme [15:0], j_imme [25:0];
  - JAL link register index 5'd31.
- Sub-module: one combinational helper, fetch_next_pc (sequential/jump/branch target mux). All state stays in instr_fetch.

Test Plan:
- Reset then 1-cycle memory returning 0x20010005 at 0x0 and 0x20020007 at 0x4, stall=0 -> imem_addr 0x0 then 0x4; F_instr/F_pc = 0x20010005/0x0, then 0x20020007/0x4; F_valid=1 for one cycle each.
- Stall held 3 cycles with F_valid=1 at F_pc=0x8 -> F_instr, F_pc, F_valid stable and imem_req=0 for 3 cycles; next request addr 0xC after stall drops.
- Jump at F_pc=0x1000_0010, ID_j_imme=26'h000_0040 -> next imem_addr=0x1000_0100; the in-flight fetch of 0x1000_0014 is discarded and never appears on F_instr.
- Branch at F_pc=0x20, ID_imme=16'hFFFC -> next fetch 0x14; ID_imme=16'h0003 -> next fetch 0x30. Also jump and branch asserted together -> jump target taken.
- 4-cycle memory latency, redirect while request outstanding -> DROP state; the old data is discarded on rvalid and the next imem_addr equals the target.
- rst pulled low mid-WAIT, rvalid arrives during reset -> all outputs at reset values; after release the first imem_addr=RESET_PC and no stale F_valid.
